// File: rtl/eth_tx_frame_buffer_if.sv
// Handshake bundle between the frame buffer, its MMIO writer and the AXIS transmit adapter.
interface eth_tx_frame_buffer_if #(
  parameter int unsigned buf_words_p = 256
);
  localparam int unsigned addr_w = $clog2(buf_words_p);

  logic              wr_v_i;
  logic [addr_w-1:0] wr_addr_i;
  logic [63:0]       wr_data_i;
  logic              wr_ready_o;
  logic              send_v_i;
  logic [15:0]       send_size_i;
  logic [2:0]        send_offset_i;
  logic              send_ready_o;
  logic [63:0]       frame_data_o;
  logic              frame_data_v_o;
  logic              frame_data_yumi_i;

  // Buffer side
  modport slave (
    input  wr_v_i, wr_addr_i, wr_data_i, send_v_i, send_size_i, send_offset_i, frame_data_yumi_i,
    output wr_ready_o, send_ready_o, frame_data_o, frame_data_v_o
  );

  // Writer / consumer side
  modport master (
    output wr_v_i, wr_addr_i, wr_data_i, send_v_i, send_size_i, send_offset_i, frame_data_yumi_i,
    input  wr_ready_o, send_ready_o, frame_data_o, frame_data_v_o
  );
endinterface

// File: rtl/eth_tx_frame_buffer.sv
// Transmit staging buffer: holds payload words, then streams one header word
// plus ceil(size/8) payload words to the AXIS transmit adapter.
module eth_tx_frame_buffer #(
  parameter int unsigned buf_words_p  = 256,
  parameter int unsigned data_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  eth_tx_frame_buffer_if.slave     bus,
  output logic                     busy_o,
  output logic                     tx_done_o,
  output logic                     send_err_o,
  output logic [15:0]              frames_sent_o
);

  localparam int unsigned addr_w    = $clog2(buf_words_p);
  localparam int unsigned last_w    = 13;
  localparam int unsigned max_bytes = buf_words_p * 8;

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;

  state_e                  state_q, state_d;
  logic [addr_w-1:0]       ptr_q, ptr_d;
  logic [15:0]             size_q, size_d;
  logic [2:0]              offset_q, offset_d;
  logic [last_w-1:0]       last_q, last_d;
  logic                    tx_done_d, send_err_d;
  logic [15:0]             frames_d;
  logic [data_width_p-1:0] mem [buf_words_p];
  logic                    size_ok_c;

  assign bus.wr_ready_o     = (state_q == IDLE);
  assign bus.send_ready_o   = (state_q == IDLE);
  assign bus.frame_data_v_o = (state_q != IDLE);
  assign busy_o             = (state_q != IDLE);
  assign size_ok_c          = (bus.send_size_i != 16'd0) && (32'(bus.send_size_i) <= max_bytes);

  // Payload storage; contents intentionally survive reset and frames
  always_ff @(posedge clk_i) begin
    if (bus.wr_v_i && bus.wr_ready_o) mem[bus.wr_addr_i] <= bus.wr_data_i;
  end

  // Output word: header carries size in [15:0] and offset in [18:16]
  always_comb begin
    bus.frame_data_o = '0;
    case (state_q)
      HDR:     bus.frame_data_o = {44'b0, 1'b0, offset_q, size_q};
      PAY:     bus.frame_data_o = mem[ptr_q];
      default: bus.frame_data_o = '0;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    size_d     = size_q;
    offset_d   = offset_q;
    last_d     = last_q;
    tx_done_d  = 1'b0;
    send_err_d = 1'b0;
    frames_d   = frames_sent_o;
    case (state_q)
      IDLE: begin
        if (bus.send_v_i) begin
          if (size_ok_c) begin
            size_d   = bus.send_size_i;
            offset_d = bus.send_offset_i;
            last_d   = last_w'((bus.send_size_i - 16'd1) >> 3);
            state_d  = HDR;
          end else begin
            send_err_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (bus.frame_data_yumi_i) begin
          ptr_d   = '0;
          state_d = PAY;
        end
      end
      PAY: begin
        if (bus.frame_data_yumi_i) begin
          if (last_w'(ptr_q) == last_q) begin
            state_d   = IDLE;
            tx_done_d = 1'b1;
            frames_d  = frames_sent_o + 16'd1;
          end else begin
            ptr_d = ptr_q + addr_w'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      size_q        <= '0;
      offset_q      <= '0;
      last_q        <= '0;
      tx_done_o     <= 1'b0;
      send_err_o    <= 1'b0;
      frames_sent_o <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      size_q        <= size_d;
      offset_q      <= offset_d;
      last_q        <= last_d;
      tx_done_o     <= tx_done_d;
      send_err_o    <= send_err_d;
      frames_sent_o <= frames_d;
    end
  end

endmodule

// File: doc/eth_tx_frame_buffer.md
# eth_tx_frame_buffer

Transmit frame staging buffer that sits directly upstream of the Ethernet AXIS transmit adapter. Software or the MMIO front end writes payload 64-bit words into an internal buffer, then issues a send command carrying byte length and head offset. The block then emits, over a valid/yumi stream, one header word followed by ceil(size/8) payload words. That is the frame format the AXIS transmit adapter consumes.

## Interface
- buf_words_p, 256: buffer depth in 64-bit words; must be a power of two and at least 190 (1518-byte frame).
- data_width_p, 64: word width; fixed at 64.
- clk_i  in  1  clock; all logic is rising-edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- wr_v_i  in  1  buffer write strobe.
- wr_addr_i  in  $clog2(buf_words_p)  word index to write.
- wr_data_i  in  64  write data.
- wr_ready_o  out  1  write accepted when wr_v_i & wr_ready_o.
- send_v_i  in  1  send command strobe.
- send_size_i  in  16  frame length in bytes.
- send_offset_i  in  3  head byte offset, forwarded in the header.
- send_ready_o  out  1  command accepted when send_v_i & send_ready_o.
- frame_data_o  out  64  header or payload word.
- frame_data_v_o  out  1  frame_data_o valid.
- frame_data_yumi_i  in  1  consumer takes the word; legal only when frame_data_v_o=1.
- busy_o  out  1  high while not IDLE.
- tx_done_o  out  1  one-cycle pulse per completed frame.
- send_err_o  out  1  one-cycle pulse for a rejected command.
- frames_sent_o  out  16  completed-frame counter; wraps at 2^16.

## Operation
- FSM states: IDLE, HDR, PAY.
- IDLE:
  - wr_ready_o=1 and send_ready_o=1.
  - A write stores wr_data_i at mem[wr_addr_i].
  - An accepted send with 1 ≤ size ≤ buf_words_p*8 latches size and offset, sets last_r=(size-1)>>3, and moves to HDR.
  - An accepted send with size 0 or size > buf_words_p*8 pulses send_err_o next cycle and stays in IDLE.
- HDR:
  - frame_data_o = {40'b0, 5'b0, offset_r[2:0]… } is written here as bits[15:0]=size_r, bits[19:16]={1'b0,offset_r}, all other bits 0.
  - frame_data_v_o=1. On yumi: ptr_r←0 and go to PAY.
- PAY:
  - frame_data_o = mem[ptr_r] (combinational read), frame_data_v_o=1.
  - On yumi with ptr_r≠last_r: ptr_r←ptr_r+1.
  - On yumi with ptr_r==last_r: go to IDLE, pulse tx_done_o, increment frames_sent_o.
- In HDR and PAY, wr_ready_o=0 and send_ready_o=0. Writes and sends presented then are not accepted and have no effect.
- A write and a send accepted in the same IDLE cycle both take effect. The write is visible to the payload read because the earliest read is two cycles later.
- frame_data_v_o stays high without yumi; frame_data_o holds stable until yumi.
- Memory contents are not reset and persist across frames; resending the same buffer is legal.
- Width rules:
  - last_r is 13 bits, computed from the 16-bit size-1 with no underflow, since size 0 is rejected.
  - ptr_r has the same width as wr_addr_i.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE; ptr_r, size_r, offset_r, frames_sent_o = 0.
  - frame_data_v_o=0, frame_data_o=0, tx_done_o=0, send_err_o=0, busy_o=0.
  - wr_ready_o=1 and send_ready_o=1 once reset is released.
- Reset mid-frame aborts immediately. No tx_done_o; the counter clears.
- Send accepted in cycle N gives header valid in N+1.
- Header yumi in cycle k gives payload word 0 valid in k+1.
- One word per cycle under continuous yumi. A frame of W payload words occupies W+1 consecutive valid cycles.
- Last yumi in cycle m: tx_done_o=1 and busy_o=0 in m+1, and the next send is accepted in m+1 at the earliest. Back-to-back frames therefore have exactly one bubble cycle between last payload word and next header.
- send_err_o is asserted in cycle N+1 for a rejected send in cycle N.

## Test plan
- Write words 0..7 with values 0x1000+i; send size=64, offset=0 → header 0x0000_0000_0000_0040, then 8 words 0x1000..0x1007; tx_done_o once; frames_sent_o=1.
- Send size=65, offset=3 → header 0x0000_0000_0003_0041, then 9 payload words; size=1 → header plus exactly 1 word.
- Random yumi backpressure with 30% duty on size=1518 → 190 words, each stable until taken, in order; no drops or duplicates.
- Send size=0 and then size=buf_words_p*8+1 → send_err_o pulses, no frame_data_v_o, state stays IDLE; size=2048 accepted.
- Writes and sends during PAY → wr_ready_o and send_ready_o are 0 and memory is unchanged; two back-to-back sends show exactly 1 idle cycle between frames.
- Drop reset_n_i mid-PAY → frame_data_v_o falls asynchronously, frames_sent_o=0, and a fresh send afterwards completes normally.
